// File: rtl/ecdh_session_sequencer_pkg.sv
// Shared widths, FSM state type and host-visible mode codes for the ECDH session sequencer.
package ecdh_pkg;

    localparam int KEY_W             = 164;
    localparam int BUS_W             = 64;
    localparam int WORDS_PER_OPERAND = 3;
    localparam int HI_W              = KEY_W - 2 * BUS_W;

    typedef enum logic [2:0] {
        ST_LOAD_K,
        ST_LOAD_PX,
        ST_LOAD_PY,
        ST_ECC_START,
        ST_ECC_WAIT,
        ST_KEY_READY,
        ST_DES_RUN,
        ST_ERROR
    } state_e;

    localparam logic [2:0] MODE_LOAD_K    = 3'd0;
    localparam logic [2:0] MODE_LOAD_PX   = 3'd1;
    localparam logic [2:0] MODE_LOAD_PY   = 3'd2;
    localparam logic [2:0] MODE_ECC       = 3'd3;
    localparam logic [2:0] MODE_KEY_READY = 3'd4;
    localparam logic [2:0] MODE_DES_RUN   = 3'd5;
    localparam logic [2:0] MODE_ERROR     = 3'd7;

    // ECC_START and ECC_WAIT share one code, so the mode is not just the raw state.
    function automatic logic [2:0] mode_of(input state_e s);
        case (s)
            ST_LOAD_K:    return MODE_LOAD_K;
            ST_LOAD_PX:   return MODE_LOAD_PX;
            ST_LOAD_PY:   return MODE_LOAD_PY;
            ST_ECC_START: return MODE_ECC;
            ST_ECC_WAIT:  return MODE_ECC;
            ST_KEY_READY: return MODE_KEY_READY;
            ST_DES_RUN:   return MODE_DES_RUN;
            default:      return MODE_ERROR;
        endcase
    endfunction

endpackage

// File: rtl/ecdh_session_sequencer_if.sv
// Bundle of host, ECC and 3DES signals seen by the session sequencer.
interface ecdh_session_sequencer_if;
    import ecdh_pkg::*;

    logic             start;
    logic             rekey;
    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] data_out;
    logic             data_ready;
    logic             busy;
    logic [2:0]       mode;
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] pix;
    logic [KEY_W-1:0] piy;
    logic             estart;
    logic             edone;
    logic [KEY_W-1:0] pox;
    logic [KEY_W-1:0] poy;
    logic [KEY_W-1:0] skx;
    logic [KEY_W-1:0] sky;
    logic [BUS_W-1:0] des_input;
    logic [BUS_W-1:0] des_output;

    modport slave (
        input  start, rekey, data_in, edone, pox, poy, des_output,
        output data_out, data_ready, busy, mode, k, pix, piy, estart, skx, sky, des_input
    );

    modport master (
        output start, rekey, data_in, edone, pox, poy, des_output,
        input  data_out, data_ready, busy, mode, k, pix, piy, estart, skx, sky, des_input
    );

endinterface

// File: rtl/ecdh_session_sequencer_operand_loader.sv
// Assembles one 164-bit operand from three LS-first bus words; last_o flags the closing word.
module operand_loader
    import ecdh_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             load_en_i,
    input  logic [BUS_W-1:0] word_i,
    output logic [KEY_W-1:0] operand_o,
    output logic             last_o
);

    localparam int CNT_W = 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] operand_q, operand_d;

    assign last_o    = load_en_i && (cnt_q == CNT_W'(WORDS_PER_OPERAND - 1));
    assign operand_o = operand_q;

    // A clear only rewinds the word position; the operand keeps its old value.
    always_comb begin
        cnt_d     = cnt_q;
        operand_d = operand_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
            case (cnt_q)
                2'd0:    operand_d[BUS_W-1:0]         = word_i;
                2'd1:    operand_d[2*BUS_W-1:BUS_W]   = word_i;
                default: operand_d[KEY_W-1:2*BUS_W]   = word_i[HI_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            operand_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
        end
    end

endmodule

// File: rtl/ecdh_session_sequencer.sv
// Sequences operand loading, one ECC point multiplication, then fixed-latency 3DES blocks.
module ecdh_session_sequencer
    import ecdh_pkg::*;
#(
    parameter int unsigned DES_LATENCY = 48,
    parameter int unsigned ECC_TIMEOUT = 1048576
) (
    input  logic                    clk,
    input  logic                    n_rst,
    ecdh_session_sequencer_if.slave bus
);

    localparam int TO_W = $clog2(ECC_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       des_cnt_q, des_cnt_d;
    logic [KEY_W-1:0] skx_q, skx_d;
    logic [KEY_W-1:0] sky_q, sky_d;
    logic [BUS_W-1:0] des_in_q, des_in_d;
    logic [BUS_W-1:0] data_out_q, data_out_d;
    logic             data_ready_q, data_ready_d;

    logic             accept;
    logic             k_last, px_last, py_last;
    logic [KEY_W-1:0] k_op, px_op, py_op;

    // A rekey in the same cycle as start discards the word.
    assign accept = bus.start && !bus.rekey;

    operand_loader u_k_loader (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (bus.rekey),
        .load_en_i (accept && (state_q == ST_LOAD_K)),
        .word_i    (bus.data_in),
        .operand_o (k_op),
        .last_o    (k_last)
    );

    operand_loader u_px_loader (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (bus.rekey),
        .load_en_i (accept && (state_q == ST_LOAD_PX)),
        .word_i    (bus.data_in),
        .operand_o (px_op),
        .last_o    (px_last)
    );

    operand_loader u_py_loader (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (bus.rekey),
        .load_en_i (accept && (state_q == ST_LOAD_PY)),
        .word_i    (bus.data_in),
        .operand_o (py_op),
        .last_o    (py_last)
    );

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        des_cnt_d    = des_cnt_q;
        skx_d        = skx_q;
        sky_d        = sky_q;
        des_in_d     = des_in_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        if (bus.rekey) begin
            state_d   = ST_LOAD_K;
            to_cnt_d  = '0;
            des_cnt_d = '0;
            skx_d     = '0;
            sky_d     = '0;
        end else begin
            case (state_q)
                ST_LOAD_K:    if (k_last)  state_d = ST_LOAD_PX;
                ST_LOAD_PX:   if (px_last) state_d = ST_LOAD_PY;
                ST_LOAD_PY:   if (py_last) state_d = ST_ECC_START;
                ST_ECC_START: begin
                    to_cnt_d = '0;
                    state_d  = ST_ECC_WAIT;
                end
                // A zero result is the point at infinity and must never become a key.
                ST_ECC_WAIT: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (bus.edone) begin
                        if ((bus.pox == '0) && (bus.poy == '0)) begin
                            state_d = ST_ERROR;
                        end else begin
                            skx_d   = bus.pox;
                            sky_d   = bus.poy;
                            state_d = ST_KEY_READY;
                        end
                    end else if (to_cnt_d == TO_W'(ECC_TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_KEY_READY: if (bus.start) begin
                    des_in_d  = bus.data_in;
                    des_cnt_d = 8'(DES_LATENCY);
                    state_d   = ST_DES_RUN;
                end
                ST_DES_RUN: begin
                    des_cnt_d = des_cnt_q - 8'd1;
                    if (des_cnt_q == 8'd1) begin
                        data_out_d   = bus.des_output;
                        data_ready_d = 1'b1;
                        state_d      = ST_KEY_READY;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_LOAD_K;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_LOAD_K;
            to_cnt_q     <= '0;
            des_cnt_q    <= '0;
            skx_q        <= '0;
            sky_q        <= '0;
            des_in_q     <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            des_cnt_q    <= des_cnt_d;
            skx_q        <= skx_d;
            sky_q        <= sky_d;
            des_in_q     <= des_in_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.mode       = mode_of(state_q);
    assign bus.busy       = (state_q == ST_ECC_START) || (state_q == ST_ECC_WAIT) || (state_q == ST_DES_RUN);
    assign bus.estart     = (state_q == ST_ECC_START);
    assign bus.k          = k_op;
    assign bus.pix        = px_op;
    assign bus.piy        = py_op;
    assign bus.skx        = skx_q;
    assign bus.sky        = sky_q;
    assign bus.des_input  = des_in_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_ecdh_session_sequencer.sv
// Directed bench: operand loading, ECC handoff, 3DES latency, error/timeout, rekey and reset.
`timescale 1ns/1ps
module tb_ecdh_session_sequencer;
    import ecdh_pkg::*;

    localparam int unsigned TB_DES_LAT = 48;
    localparam int unsigned TB_ECC_TO  = 100;
    localparam logic [KEY_W-1:0] GX = 164'h2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8;
    localparam logic [KEY_W-1:0] GY = 164'h289070FB05D38FF58321F2E800536D538CCDAA3D9;

    typedef struct {
        logic [BUS_W-1:0] word;
        logic [2:0]       expMode;
        logic             expEstart;
    } loadVec_t;

    typedef struct {
        logic [BUS_W-1:0] din;
        logic [BUS_W-1:0] expOut;
    } desVec_t;

    logic clk = 1'b0;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;

    loadVec_t loadTbl[9];
    desVec_t  desTbl[3];

    ecdh_session_sequencer_if bus();

    ecdh_session_sequencer #(
        .DES_LATENCY (TB_DES_LAT),
        .ECC_TIMEOUT (TB_ECC_TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // 3DES stand-in: bitwise inverse, so 0123456789ABCDEF maps to FEDCBA9876543210.
    assign bus.des_output = ~bus.des_input;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [BUS_W-1:0] d);
        bus.start   = s;
        bus.rekey   = r;
        bus.data_in = d;
        tick();
        bus.start = 1'b0;
        bus.rekey = 1'b0;
    endtask

    function automatic logic [BUS_W-1:0] wordOf(input logic [KEY_W-1:0] v, input int idx);
        case (idx)
            0:       return v[BUS_W-1:0];
            1:       return v[2*BUS_W-1:BUS_W];
            default: return {28'hABCDEF1, v[KEY_W-1:2*BUS_W]};
        endcase
    endfunction

    task automatic loadSession(input logic [KEY_W-1:0] kv, input logic [KEY_W-1:0] pxv,
                               input logic [KEY_W-1:0] pyv, input string tag);
        logic [KEY_W-1:0] ops[3];
        logic [2:0]       modeSeq[9];
        ops     = '{kv, pxv, pyv};
        modeSeq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        for (int i = 0; i < 9; i++) begin
            loadTbl[i].word      = wordOf(ops[i / 3], i % 3);
            loadTbl[i].expMode   = modeSeq[i];
            loadTbl[i].expEstart = (i == 8);
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, loadTbl[i].word);
            checkOutput($sformatf("%s_mode_w%0d", tag, i), KEY_W'(bus.mode), KEY_W'(loadTbl[i].expMode));
            checkOutput($sformatf("%s_estart_w%0d", tag, i), KEY_W'(bus.estart), KEY_W'(loadTbl[i].expEstart));
        end
        checkOutput({tag, "_k"}, bus.k, kv);
        checkOutput({tag, "_pix"}, bus.pix, pxv);
        checkOutput({tag, "_piy"}, bus.piy, pyv);
    endtask

    initial begin
        int lat;
        bus.start   = 1'b0;
        bus.rekey   = 1'b0;
        bus.data_in = '0;
        bus.edone   = 1'b0;
        bus.pox     = '0;
        bus.poy     = '0;
        n_rst       = 1'b0;
        repeat (2) tick();

        checkOutput("rst_mode", KEY_W'(bus.mode), KEY_W'(3'd0));
        checkOutput("rst_busy", KEY_W'(bus.busy), '0);
        checkOutput("rst_estart", KEY_W'(bus.estart), '0);
        checkOutput("rst_data_ready", KEY_W'(bus.data_ready), '0);
        checkOutput("rst_data_out", KEY_W'(bus.data_out), '0);
        checkOutput("rst_des_input", KEY_W'(bus.des_input), '0);
        checkOutput("rst_skx", bus.skx, '0);
        checkOutput("rst_k", bus.k, '0);
        n_rst = 1'b1;

        // Session 1: successful agreement; pox/poy preset but not strobed must not latch.
        bus.pox = 164'h5;
        bus.poy = 164'h6;
        loadSession(164'd1, GX, GY, "s1");
        tick();
        checkOutput("s1_estart_once", KEY_W'(bus.estart), '0);
        checkOutput("s1_wait_mode", KEY_W'(bus.mode), KEY_W'(3'd3));
        checkOutput("s1_wait_busy", KEY_W'(bus.busy), KEY_W'(1'b1));
        repeat (3) tick();
        checkOutput("s1_skx_pre", bus.skx, '0);
        bus.edone = 1'b1;
        bus.pox   = 164'h123;
        bus.poy   = 164'h456;
        tick();
        bus.edone = 1'b0;
        checkOutput("s1_key_mode", KEY_W'(bus.mode), KEY_W'(3'd4));
        checkOutput("s1_skx", bus.skx, 164'h123);
        checkOutput("s1_sky", bus.sky, 164'h456);
        checkOutput("s1_key_busy", KEY_W'(bus.busy), '0);

        bus.edone = 1'b1;
        bus.pox   = 164'h999;
        tick();
        bus.edone = 1'b0;
        checkOutput("stray_edone_skx", bus.skx, 164'h123);
        checkOutput("stray_edone_mode", KEY_W'(bus.mode), KEY_W'(3'd4));

        // Blocks run back-to-back; vector 1 also sees a dropped start mid-flight.
        desTbl[0] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        desTbl[1] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF};
        desTbl[2] = '{64'hA5A50F0F3C3C9669, 64'h5A5AF0F0C3C36996};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, desTbl[i].din);
            lat = 1;
            checkOutput($sformatf("des%0d_run_mode", i), KEY_W'(bus.mode), KEY_W'(3'd5));
            checkOutput($sformatf("des%0d_ready_pulse", i), KEY_W'(bus.data_ready), '0);
            while (!bus.data_ready && lat < 300) begin
                if (i == 1 && lat == 10) begin
                    bus.start   = 1'b1;
                    bus.data_in = 64'hAAAAAAAAAAAAAAAA;
                end
                tick();
                bus.start = 1'b0;
                lat++;
            end
            checkOutput($sformatf("des%0d_latency", i), KEY_W'(lat), KEY_W'(TB_DES_LAT + 1));
            checkOutput($sformatf("des%0d_ready", i), KEY_W'(bus.data_ready), KEY_W'(1'b1));
            checkOutput($sformatf("des%0d_data_out", i), KEY_W'(bus.data_out), KEY_W'(desTbl[i].expOut));
            checkOutput($sformatf("des%0d_des_input", i), KEY_W'(bus.des_input), KEY_W'(desTbl[i].din));
            checkOutput($sformatf("des%0d_done_mode", i), KEY_W'(bus.mode), KEY_W'(3'd4));
        end
        tick();
        checkOutput("des_last_pulse_end", KEY_W'(bus.data_ready), '0);
        checkOutput("des_idle_mode", KEY_W'(bus.mode), KEY_W'(3'd4));

        // rekey and start together: word discarded, counters cleared, k retained.
        applyStimulus(1'b1, 1'b1, 64'h1111111111111111);
        checkOutput("rk_mode", KEY_W'(bus.mode), KEY_W'(3'd0));
        checkOutput("rk_skx", bus.skx, '0);
        checkOutput("rk_sky", bus.sky, '0);
        checkOutput("rk_k_kept", bus.k, 164'd1);
        checkOutput("rk_data_out_kept", KEY_W'(bus.data_out), KEY_W'(desTbl[2].expOut));

        // Session 2: point at infinity leads to ERROR, which ignores start.
        loadSession(164'd5, GX, GY, "s2");
        tick();
        bus.edone = 1'b1;
        bus.pox   = '0;
        bus.poy   = '0;
        tick();
        bus.edone = 1'b0;
        checkOutput("inf_mode", KEY_W'(bus.mode), KEY_W'(3'd7));
        checkOutput("inf_skx", bus.skx, '0);
        checkOutput("inf_sky", bus.sky, '0);
        applyStimulus(1'b1, 1'b0, 64'h7777777777777777);
        tick();
        checkOutput("err_start_mode", KEY_W'(bus.mode), KEY_W'(3'd7));
        checkOutput("err_start_des_input", KEY_W'(bus.des_input), KEY_W'(desTbl[2].din));
        checkOutput("err_start_ready", KEY_W'(bus.data_ready), '0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("err_rekey_mode", KEY_W'(bus.mode), KEY_W'(3'd0));

        // Session 3: edone never arrives.
        loadSession(164'd3, GX, GY, "s3");
        repeat (TB_ECC_TO) tick();
        checkOutput("to_before", KEY_W'(bus.mode), KEY_W'(3'd3));
        tick();
        checkOutput("to_hit", KEY_W'(bus.mode), KEY_W'(3'd7));
        applyStimulus(1'b0, 1'b1, '0);

        // Session 4: reset while waiting, then a late edone must be ignored.
        loadSession(164'd7, GX, GY, "s4");
        repeat (2) tick();
        n_rst = 1'b0;
        tick();
        n_rst     = 1'b1;
        bus.edone = 1'b1;
        bus.pox   = 164'h777;
        bus.poy   = 164'h888;
        tick();
        bus.edone = 1'b0;
        checkOutput("rstwait_mode", KEY_W'(bus.mode), KEY_W'(3'd0));
        checkOutput("rstwait_skx", bus.skx, '0);
        checkOutput("rstwait_sky", bus.sky, '0);
        checkOutput("rstwait_k", bus.k, '0);
        checkOutput("rstwait_busy", KEY_W'(bus.busy), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
